clk_div_prog: RTL
=================

// Module: clk_div_prog
// PURPOSE
//  Runtime-programmable clock divider/tick generator; parametrised successor to the fixed 6,250,000 divider.
//  Produces a 50%-duty divided clock plus single-cycle strobes for the DPWM counters and button-scan FSMs.
//  Divisor is reloaded at runtime through a valid/ready handshake and applied only at a terminal count, so it never glitches.
//  Sits between the board clock and every DPWM/state-machine clock-enable consumer.
// PARAMETERS
//  CNT_W        23        counter and divisor width, in bits
//  DEFAULT_DIV  6250000   active divisor after reset; must fit in CNT_W bits
// PORTS
//  clk        in   1      system clock (100 MHz)
//  reset      in   1      asynchronous, active-high reset
//  en         in   1      count enable; low freezes counter and outputs
//  div_val    in   CNT_W  new divisor N: half-period = N+1 clk cycles
//  div_load   in   1      div_val valid; transfer occurs when div_load & div_ready
//  div_ready  out  1      high when no divisor is pending
//  clk_out    out  1      divided clock; period 2*(N+1) clk cycles
//  tick       out  1      1-cycle strobe on every clk_out toggle
//  rise       out  1      1-cycle strobe when clk_out goes 0->1
//  div_active out  CNT_W  divisor currently in use
// BEHAVIOUR
//  Reset values (async): cnt=0, clk_out=0, tick=0, rise=0, div_active=DEFAULT_DIV, pending empty, div_ready=1.
//  Counting: when en=1 and cnt==div_active, cnt<=0, clk_out<=~clk_out, tick<=1, rise<=~clk_out. Otherwise cnt<=cnt+1 and tick=rise=0.
//  tick and rise are registered: they assert in the same cycle in which the new clk_out value is visible.
//  N=0: clk_out toggles every cycle (clk/2); tick is held high continuously while en=1.
//  Counter arithmetic is unsigned CNT_W bits. cnt never exceeds div_active, so it never wraps.
//  Handshake: div_load & div_ready captures div_val into the pending register; div_ready<=0 on the next edge.
//   div_load while div_ready=0 is ignored; the previously pending value is kept.
//  Apply, en=1: at the edge where cnt==div_active (the wrap edge), div_active<=pending and div_ready<=1.
//   The new value governs the next half-period.
//  Apply, en=0: pending is applied on the next edge, and cnt<=0 on that same edge.
//  Load accepted on the same edge as a wrap: not applied on that wrap; it waits for the following terminal count.
//  en=0: cnt, clk_out and div_active hold; tick=rise=0.
//  Reset mid-operation: pending value discarded; all state returns to reset values immediately.
// CONFIGURATION
//  CLKDIV_SYNC_EN defined: adds input sync_in (1 bit) for phase-aligning several dividers.
//   On sync_in=1: cnt<=0, clk_out<=0, tick=rise=0, and any pending divisor is applied at once (div_ready<=1).
//   sync_in has priority over en and over the wrap and apply rules.
//   sync_in must be synchronous to clk.
//  CLKDIV_SYNC_EN undefined: there is no sync_in port and no resync logic.
// TESTING
//  1. DEFAULT_DIV=3, en=1 after reset -> first clk_out rise at the 4th edge; period 8 clk; tick every 4 cycles; rise every 8 cycles.
//  2. N=0 loaded while en=1 -> after the next wrap, clk_out toggles every cycle and tick stays high.
//  3. Load 5 mid half-period with div_active=3 -> div_ready=0 until the wrap; the next half-period is 6 cycles; div_active==5.
//  4. Second div_load while div_ready=0 (value 9 after 5) -> the 9 is ignored and 5 is applied.
//  5. en=0 for 10 cycles mid-count -> cnt and clk_out frozen, no ticks; the count resumes from the frozen value.
//     Load with en=0 -> applied next cycle and cnt=0.
//  6. Reset asserted mid-count with a divisor pending -> outputs 0 immediately, div_active=DEFAULT_DIV, div_ready=1.
//     [SYNC_EN] sync_in pulse at cnt=2 -> clk_out=0 and cnt=0 the next cycle.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: 50% clk_out plus tick/rise strobes, with a glitch-free divisor reload.
// Optional phase-alignment input sync_in is compiled in when CLKDIV_SYNC_EN is defined.
module clk_div_prog #(
    parameter int unsigned CNT_W       = 23,
    parameter int unsigned DEFAULT_DIV = 6250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             rise,
    output logic [CNT_W-1:0] div_active
);

    localparam logic [CNT_W-1:0] DEFAULT_DIV_C = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C     = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ready_q, ready_d;
    logic             apply_s;

    // Next-state logic: handshake capture, counting/wrap, and divisor apply.
    always_comb begin
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        rise_d       = 1'b0;
        div_active_d = div_active_q;
        pend_d       = pend_q;
        ready_d      = ready_q;
        apply_s      = 1'b0;

        if (div_load && ready_q) begin
            pend_d  = div_val;
            ready_d = 1'b0;
        end else begin
            pend_d  = pend_q;
        end

`ifdef CLKDIV_SYNC_EN
        if (sync_in) begin
            cnt_d     = CNT_ZERO_C;
            clk_out_d = 1'b0;
            apply_s   = ~ready_q;
        end else
`endif
        if (en) begin
            if (cnt_q == div_active_q) begin
                cnt_d     = CNT_ZERO_C;
                clk_out_d = ~clk_out_q;
                tick_d    = 1'b1;
                rise_d    = ~clk_out_q;
                apply_s   = ~ready_q;
            end else begin
                cnt_d     = cnt_q + CNT_ONE_C;
            end
        end else begin
            // While stopped there is no half-period to protect, so a pending divisor lands immediately.
            if (!ready_q) begin
                cnt_d   = CNT_ZERO_C;
                apply_s = 1'b1;
            end else begin
                cnt_d   = cnt_q;
            end
        end

        // apply and accept are exclusive: accept needs ready_q=1, apply needs ready_q=0.
        if (apply_s) begin
            div_active_d = pend_q;
            ready_d      = 1'b1;
        end else begin
            div_active_d = div_active_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= CNT_ZERO_C;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            rise_q       <= 1'b0;
            div_active_q <= DEFAULT_DIV_C;
            pend_q       <= CNT_ZERO_C;
            ready_q      <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            rise_q       <= rise_d;
            div_active_q <= div_active_d;
            pend_q       <= pend_d;
            ready_q      <= ready_d;
        end
    end

    assign div_ready  = ready_q;
    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign rise       = rise_q;
    assign div_active = div_active_q;

endmodule
